// File: rtl/axis_out_pkg.sv
// Package for the ping-pong AXI4-Stream output serializer.
// Contents: FSM state enum, ceil-divide helper and the derived per-row beat
// and padding computations shared by the top and the beat counter.
package axis_out_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned beats_per_row(input int unsigned row_bits,
                                                input int unsigned packet_size);
    return ceil_div(row_bits, packet_size);
  endfunction

  // Zero LSBs appended to the last beat of each row.
  function automatic int unsigned pad_bits(input int unsigned row_bits,
                                           input int unsigned packet_size);
    return beats_per_row(row_bits, packet_size) * packet_size - row_bits;
  endfunction

endpackage

// File: rtl/axi4stream_output_serializer_pp_if.sv
// Bundle of the frame-input handshake, the AXI4-Stream master signals and
// the status outputs of axi4stream_output_serializer_pp.
//   slave  : view of the serializer (frame in, stream out, status out)
//   master : view of the environment driving it
// Optional macro AXIS_OUT_TKEEP_EN adds tkeep (PACKET_SIZE/8 lanes).
interface axi4stream_output_serializer_pp_if #(
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned BUFFER_SIZE = 40,
  parameter int unsigned CNT_W       = 16
);
  logic [BUFFER_SIZE-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [PACKET_SIZE-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tuser;
  logic                   tready;
  logic                   busy;
  logic [CNT_W-1:0]       frame_count;
`ifdef AXIS_OUT_TKEEP_EN
  logic [PACKET_SIZE/8-1:0] tkeep;
`endif

  modport slave (
    input  in_data, in_valid, tready,
    output in_ready, tdata, tvalid, tlast, tuser, busy, frame_count
`ifdef AXIS_OUT_TKEEP_EN
    , output tkeep
`endif
  );

  modport master (
    output in_data, in_valid, tready,
    input  in_ready, tdata, tvalid, tlast, tuser, busy, frame_count
`ifdef AXIS_OUT_TKEEP_EN
    , input tkeep
`endif
  );

endinterface

// File: rtl/axis_row_beat_counter.sv
// Beat/row position tracker for the output serializer.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   adv_i         : a beat was transferred this cycle
//   last_beat_o   : current beat is the last of its row
//   first_beat_o  : current beat is the first of the frame
//   final_beat_o  : current beat is the last of the frame
module axis_row_beat_counter #(
  parameter int unsigned BEATS_PER_ROW = 3,
  parameter int unsigned NROWS         = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  output logic last_beat_o,
  output logic first_beat_o,
  output logic final_beat_o
);
  localparam int unsigned BEAT_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int unsigned ROW_W  = (NROWS > 1) ? $clog2(NROWS) : 1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              last_row;

  assign last_beat_o  = (beat_q == BEAT_W'(BEATS_PER_ROW - 1));
  assign last_row     = (row_q == ROW_W'(NROWS - 1));
  assign first_beat_o = (beat_q == '0) && (row_q == '0);
  assign final_beat_o = last_beat_o && last_row;

  always_comb begin
    beat_d = beat_q;
    row_d  = row_q;
    if (adv_i) begin
      if (last_beat_o) begin
        beat_d = '0;
        row_d  = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      row_q  <= '0;
    end else begin
      beat_q <= beat_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/axi4stream_output_serializer_pp.sv
// Ping-pong frame serializer: accepts a NROWS x ROW_BITS frame and streams it
// MSB-first on an AXI4-Stream master, PACKET_SIZE bits per beat, each row
// beat-aligned and closed with tlast; tuser marks start of frame. A holding
// register lets the next frame arrive while the current one streams.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   bus (slave)  : in_data/in_valid/in_ready, tdata/tvalid/tlast/tuser/tready,
//                  busy, frame_count (and tkeep with AXIS_OUT_TKEEP_EN)
// Optional macro AXIS_OUT_TKEEP_EN: adds tkeep; PACKET_SIZE must be a
// multiple of 8.
module axi4stream_output_serializer_pp
  import axis_out_pkg::*;
#(
  parameter int unsigned PACKET_SIZE = 8,
  parameter int unsigned ROW_BITS    = 20,
  parameter int unsigned NROWS       = 2,
  parameter int unsigned CNT_W       = 16
) (
  input logic                               aclk,
  input logic                               areset,
  axi4stream_output_serializer_pp_if.slave  bus
);
  localparam int unsigned BUFFER_SIZE   = ROW_BITS * NROWS;
  localparam int unsigned BEATS_PER_ROW = beats_per_row(ROW_BITS, PACKET_SIZE);
  localparam int unsigned PAD           = pad_bits(ROW_BITS, PACKET_SIZE);
  // Shift register carries one spare beat of zeros below the frame so the
  // top PACKET_SIZE bits are always addressable, even for tiny frames.
  localparam int unsigned SR_W          = BUFFER_SIZE + PACKET_SIZE;
  localparam int unsigned LAST_SHIFT    = PACKET_SIZE - PAD;
  localparam logic [PACKET_SIZE-1:0] LAST_MASK = {PACKET_SIZE{1'b1}} << PAD;

  state_e                 state_q, state_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [BUFFER_SIZE-1:0] hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   in_ready_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic tvalid, xfer, accept;
  logic last_beat, first_beat, final_beat;
  logic [PACKET_SIZE-1:0] top_bits;

  assign tvalid   = (state_q == SEND);
  assign xfer     = tvalid && bus.tready;
  assign accept   = bus.in_valid && in_ready_q;
  assign top_bits = sr_q[SR_W-1 -: PACKET_SIZE];

  axis_row_beat_counter #(
    .BEATS_PER_ROW (BEATS_PER_ROW),
    .NROWS         (NROWS)
  ) u_cnt (
    .clk_i        (aclk),
    .rst_i        (areset),
    .adv_i        (xfer),
    .last_beat_o  (last_beat),
    .first_beat_o (first_beat),
    .final_beat_o (final_beat)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = {bus.in_data, {PACKET_SIZE{1'b0}}};
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer)
          sr_d = last_beat ? (sr_q << LAST_SHIFT) : (sr_q << PACKET_SIZE);
        if (xfer && final_beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          // Next frame (held or arriving now) replaces the active one on the
          // same edge, so the stream has no bubble between frames.
          if (hold_full_q) begin
            sr_d        = {hold_q, {PACKET_SIZE{1'b0}}};
            hold_full_d = 1'b0;
          end else if (accept) begin
            sr_d = {bus.in_data, {PACKET_SIZE{1'b0}}};
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          hold_d      = bus.in_data;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= !hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.tvalid      = tvalid;
  assign bus.tdata       = !tvalid ? '0 : (last_beat ? (top_bits & LAST_MASK) : top_bits);
  assign bus.tlast       = tvalid && last_beat;
  assign bus.tuser       = tvalid && first_beat;
  assign bus.busy        = (state_q == SEND) || hold_full_q;
  assign bus.frame_count = cnt_q;

`ifdef AXIS_OUT_TKEEP_EN
  localparam int unsigned KEEP_W = PACKET_SIZE / 8;
  if ((PACKET_SIZE % 8) != 0) begin : g_keep_chk
    $error("AXIS_OUT_TKEEP_EN requires PACKET_SIZE to be a multiple of 8");
  end
  // Lane j counts from the LSB; a lane is kept on the row's last beat when
  // its MSB-first byte position starts inside the valid (unpadded) bits.
  logic [KEEP_W-1:0] keep_last;
  for (genvar j = 0; j < KEEP_W; j++) begin : g_keep
    assign keep_last[j] = ((KEEP_W - 1 - j) * 8 < LAST_SHIFT);
  end
  assign bus.tkeep = !tvalid ? '0 : (last_beat ? keep_last : '1);
`endif

endmodule

// File: tb/tb_axi4stream_output_serializer_pp.sv
module tb_axi4stream_output_serializer_pp;

`ifdef AXIS_OUT_TKEEP_EN
  localparam int unsigned P2 = 16;
`else
  localparam int unsigned P2 = 10;
`endif

  logic aclk = 1'b0;
  logic areset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 aclk = ~aclk;

  axi4stream_output_serializer_pp_if #(.PACKET_SIZE(8), .BUFFER_SIZE(40), .CNT_W(16)) bus1 ();
  axi4stream_output_serializer_pp_if #(.PACKET_SIZE(P2), .BUFFER_SIZE(20), .CNT_W(16)) bus2 ();

  axi4stream_output_serializer_pp #(
    .PACKET_SIZE(8), .ROW_BITS(20), .NROWS(2), .CNT_W(16)
  ) dut1 (
    .aclk(aclk), .areset(areset), .bus(bus1)
  );

  axi4stream_output_serializer_pp #(
    .PACKET_SIZE(P2), .ROW_BITS(20), .NROWS(1), .CNT_W(16)
  ) dut2 (
    .aclk(aclk), .areset(areset), .bus(bus2)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the beat currently presented by dut1, then let the edge pass.
  task automatic beat1(input string tag, input logic [7:0] d, input logic l, input logic u);
    chk({tag, ".tvalid"}, 64'(bus1.tvalid), 64'(1));
    chk({tag, ".tdata"},  64'(bus1.tdata),  64'(d));
    chk({tag, ".tlast"},  64'(bus1.tlast),  64'(l));
    chk({tag, ".tuser"},  64'(bus1.tuser),  64'(u));
`ifdef AXIS_OUT_TKEEP_EN
    chk({tag, ".tkeep"},  64'(bus1.tkeep),  64'(1));
`endif
    tick();
  endtask

  task automatic accept1(input logic [39:0] d);
    bus1.in_data  = d;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
  endtask

  task automatic frame_a(input string tag);
    beat1({tag, ".b0"}, 8'h12, 1'b0, 1'b1);
    beat1({tag, ".b1"}, 8'h34, 1'b0, 1'b0);
    beat1({tag, ".b2"}, 8'hF0, 1'b1, 1'b0);
    beat1({tag, ".b3"}, 8'hAB, 1'b0, 1'b0);
    beat1({tag, ".b4"}, 8'hCD, 1'b0, 1'b0);
    beat1({tag, ".b5"}, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    areset        = 1'b1;
    bus1.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.tready   = 1'b1;
    bus2.in_data  = '0;
    bus2.in_valid = 1'b0;
    bus2.tready   = 1'b1;
    tick();
    tick();
    areset = 1'b0;

    // Reset state
    chk("rst.tvalid",   64'(bus1.tvalid),      64'(0));
    chk("rst.tdata",    64'(bus1.tdata),       64'(0));
    chk("rst.tlast",    64'(bus1.tlast),       64'(0));
    chk("rst.tuser",    64'(bus1.tuser),       64'(0));
    chk("rst.in_ready", 64'(bus1.in_ready),    64'(1));
    chk("rst.busy",     64'(bus1.busy),        64'(0));
    chk("rst.fc",       64'(bus1.frame_count), 64'(0));
`ifdef AXIS_OUT_TKEEP_EN
    chk("rst.tkeep",    64'(bus1.tkeep),       64'(0));
`endif

    // Single frame, tready always high, first beat one cycle after accept
    accept1(40'h1234FABCD0);
    chk("t1.busy", 64'(bus1.busy), 64'(1));
    frame_a("t1");
    chk("t1.idle",   64'(bus1.tvalid),      64'(0));
    chk("t1.fc",     64'(bus1.frame_count), 64'(1));
    chk("t1.busy0",  64'(bus1.busy),        64'(0));
    chk("t1.ready",  64'(bus1.in_ready),    64'(1));

    // Stall for two cycles while beat 34 is presented
    accept1(40'h1234FABCD0);
    beat1("t2.b0", 8'h12, 1'b0, 1'b1);
    bus1.tready = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      chk("t2.stall.tvalid", 64'(bus1.tvalid), 64'(1));
      chk("t2.stall.tdata",  64'(bus1.tdata),  64'(8'h34));
      chk("t2.stall.tlast",  64'(bus1.tlast),  64'(0));
      chk("t2.stall.tuser",  64'(bus1.tuser),  64'(0));
      tick();
    end
    bus1.tready = 1'b1;
    beat1("t2.b1", 8'h34, 1'b0, 1'b0);
    beat1("t2.b2", 8'hF0, 1'b1, 1'b0);
    beat1("t2.b3", 8'hAB, 1'b0, 1'b0);
    beat1("t2.b4", 8'hCD, 1'b0, 1'b0);
    beat1("t2.b5", 8'h00, 1'b1, 1'b0);
    chk("t2.idle", 64'(bus1.tvalid),      64'(0));
    chk("t2.fc",   64'(bus1.frame_count), 64'(2));

    // Back-to-back frames through the holding register
    areset = 1'b1;
    tick();
    areset = 1'b0;
    bus1.in_data  = 40'h1234FABCD0;
    bus1.in_valid = 1'b1;
    tick();
    chk("t3.ready_a", 64'(bus1.in_ready), 64'(1));
    bus1.in_data = 40'h0000012345;
    beat1("t3.a0", 8'h12, 1'b0, 1'b1);
    bus1.in_valid = 1'b0;
    chk("t3.ready_held", 64'(bus1.in_ready), 64'(0));
    chk("t3.busy",       64'(bus1.busy),     64'(1));
    beat1("t3.a1", 8'h34, 1'b0, 1'b0);
    beat1("t3.a2", 8'hF0, 1'b1, 1'b0);
    beat1("t3.a3", 8'hAB, 1'b0, 1'b0);
    beat1("t3.a4", 8'hCD, 1'b0, 1'b0);
    beat1("t3.a5", 8'h00, 1'b1, 1'b0);
    chk("t3.ready_b", 64'(bus1.in_ready),    64'(1));
    chk("t3.fc_mid",  64'(bus1.frame_count), 64'(1));
    beat1("t3.b0", 8'h00, 1'b0, 1'b1);
    beat1("t3.b1", 8'h00, 1'b0, 1'b0);
    beat1("t3.b2", 8'h00, 1'b1, 1'b0);
    beat1("t3.b3", 8'h12, 1'b0, 1'b0);
    beat1("t3.b4", 8'h34, 1'b0, 1'b0);
    beat1("t3.b5", 8'h50, 1'b1, 1'b0);
    chk("t3.idle", 64'(bus1.tvalid),      64'(0));
    chk("t3.fc",   64'(bus1.frame_count), 64'(2));

    // Reset while beat AB is presented discards the frame
    accept1(40'h1234FABCD0);
    beat1("t4.b0", 8'h12, 1'b0, 1'b1);
    beat1("t4.b1", 8'h34, 1'b0, 1'b0);
    beat1("t4.b2", 8'hF0, 1'b1, 1'b0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("t4.tvalid",   64'(bus1.tvalid),      64'(0));
    chk("t4.busy",     64'(bus1.busy),        64'(0));
    chk("t4.fc",       64'(bus1.frame_count), 64'(0));
    chk("t4.in_ready", 64'(bus1.in_ready),    64'(1));
    tick();
    chk("t4.still_idle", 64'(bus1.tvalid), 64'(0));
    accept1(40'h1234FABCD0);
    frame_a("t4r");
    chk("t4.fc1", 64'(bus1.frame_count), 64'(1));

    // Single-row configuration on the second instance
    chk("t5.rst_tvalid", 64'(bus2.tvalid), 64'(0));
    bus2.in_data  = 20'hFFFFF;
    bus2.in_valid = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    chk("t5.b0.tvalid", 64'(bus2.tvalid), 64'(1));
    chk("t5.b0.tuser",  64'(bus2.tuser),  64'(1));
    chk("t5.b0.tlast",  64'(bus2.tlast),  64'(0));
`ifdef AXIS_OUT_TKEEP_EN
    chk("t5.b0.tdata",  64'(bus2.tdata),  64'(16'hFFFF));
    chk("t5.b0.tkeep",  64'(bus2.tkeep),  64'(2'b11));
`else
    chk("t5.b0.tdata",  64'(bus2.tdata),  64'(10'h3FF));
`endif
    tick();
    chk("t5.b1.tvalid", 64'(bus2.tvalid), 64'(1));
    chk("t5.b1.tuser",  64'(bus2.tuser),  64'(0));
    chk("t5.b1.tlast",  64'(bus2.tlast),  64'(1));
`ifdef AXIS_OUT_TKEEP_EN
    chk("t5.b1.tdata",  64'(bus2.tdata),  64'(16'hF000));
    chk("t5.b1.tkeep",  64'(bus2.tkeep),  64'(2'b10));
`else
    chk("t5.b1.tdata",  64'(bus2.tdata),  64'(10'h3FF));
`endif
    tick();
    chk("t5.idle", 64'(bus2.tvalid),      64'(0));
    chk("t5.fc",   64'(bus2.frame_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi4stream_output_serializer_pp.md
Name: axi4stream_output_serializer_pp

Overview:
- Parametrised successor to the single-buffer AXI4-Stream output buffer.
- Accepts a full frame buffer (NROWS rows of ROW_BITS bits each) over a valid/ready input handshake.
- Serialises the frame MSB-first onto an AXI4-Stream master, PACKET_SIZE bits per beat; each row starts beat-aligned and ends with tlast.
- Ping-pong (active + holding) storage lets the upstream upscaler deliver frame N+1 while frame N streams.

Parameters:
- PACKET_SIZE, 8, tdata width in bits (>=1).
- ROW_BITS, 20, bits per row (>=1); need not be a multiple of PACKET_SIZE.
- NROWS, 2, rows per buffer (>=1).
- CNT_W, 16, width of the frame counter.
- Derived localparams (not overridable):
  - BUFFER_SIZE = ROW_BITS*NROWS.
  - BEATS_PER_ROW = ceil(ROW_BITS/PACKET_SIZE).
  - PAD = BEATS_PER_ROW*PACKET_SIZE - ROW_BITS.

Ports:
- aclk, input, 1, clock; all logic on the rising edge.
- areset, input, 1, synchronous active-high reset.
- in_data, input, BUFFER_SIZE, frame buffer; row 0 occupies the MSBs.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block can accept a frame.
- tdata, output, PACKET_SIZE, stream data.
- tvalid, output, 1, stream data valid.
- tlast, output, 1, last beat of a row.
- tuser, output, 1, first beat of a frame (SOF).
- tready, input, 1, downstream ready.
- busy, output, 1, active or holding register occupied.
- frame_count, output, CNT_W, frames fully transmitted; wraps modulo 2^CNT_W.

Behaviour:
- Reset (areset=1 at an edge):
  - tvalid=0, tlast=0, tuser=0, tdata=0.
  - in_ready=1 on the next cycle; busy=0; frame_count=0.
  - Both storage registers invalidated and counters cleared. A reset mid-frame discards all in-flight data; no partial row is finished.
- Input handshake:
  - Accept when in_valid && in_ready at the edge.
  - in_ready = !hold_full (registered, derived from state). It never depends combinationally on in_valid or tready.
- Storage:
  - active_reg (shifting) plus hold_reg.
  - Accept while IDLE: load active_reg directly; first beat tvalid=1 on the next cycle (1-cycle latency).
  - Accept while SEND: load hold_reg. hold_reg moves into active_reg on the edge that completes the final beat of the current frame, so there is no bubble between frames.
- FSM:
  - IDLE -> SEND on accept.
  - SEND -> SEND on final beat if hold_full (or an accept happens that same edge into an empty hold).
  - SEND -> IDLE on final beat otherwise.
  - Simultaneous final beat + accept while hold_full: impossible, since in_ready=0.
  - Simultaneous final beat + accept with hold empty: the new frame goes straight to active_reg; no idle cycle.
- Beat generation:
  - beat_cnt runs 0..BEATS_PER_ROW-1; row_cnt runs 0..NROWS-1.
  - A beat is transferred when tvalid && tready; counters advance only on transfer.
  - tdata = next PACKET_SIZE bits of the current row, MSB first. The final row beat carries the remaining bits left-justified, with PAD zero LSBs.
  - tlast=1 when beat_cnt==BEATS_PER_ROW-1.
  - tuser=1 when beat_cnt==0 && row_cnt==0.
- AXI rules:
  - tvalid never depends on tready.
  - While tvalid && !tready, tdata/tlast/tuser are held stable.
  - tready deasserting mid-row stalls the stream without loss.
- frame_count increments on the final beat transfer of each frame.

Optional Feature:
- Macro AXIS_OUT_TKEEP_EN.
- Defined:
  - Adds port tkeep, output, PACKET_SIZE/8. PACKET_SIZE must be a multiple of 8; otherwise a compile-time error is raised.
  - tkeep is all-ones except on a row's final beat, where byte lanes holding only padding are 0 (lanes are MSB-first).
  - Reset value 0.
- Undefined: no tkeep port; padding is sent as zero data.

Decomposition:
- Package axis_out_pkg: FSM state enum (IDLE, SEND), a ceil-divide constant function, and the derived BEATS_PER_ROW/PAD computation.
- One sub-module: axis_row_beat_counter, covering beat_cnt/row_cnt, tlast/tuser and final-beat generation.

Test Plan:
- Reset; in_data=40'h1234FABCD0 (row0=20'h1234F, row1=20'hABCD0), tready=1 -> beats 12(tuser), 34, F0(tlast), AB, CD, 00(tlast) on consecutive cycles; first tvalid 1 cycle after accept; frame_count=1.
- Same frame, tready low for 2 cycles after beat 1 -> beat 34 is held stable throughout the stall; sequence is unchanged and no beat is dropped or duplicated.
- Two frames back-to-back (second 40'h0000012345) with in_valid held -> second frame accepted into hold_reg during the first (in_ready then 0); tuser beat of frame 2 directly follows the final 00 beat with no gap; frame_count=2.
- areset pulsed during beat 3 -> the next cycle shows tvalid=0, busy=0, frame_count=0; a new frame then streams from beat 0 with tuser.
- PACKET_SIZE=10, ROW_BITS=20, NROWS=1, in_data=20'hFFFFF -> exactly 2 beats, 3FF then 3FF(tlast); no padding beat.
- AXIS_OUT_TKEEP_EN defined, default parameters -> tkeep=1 on every beat (single byte lane). Then PACKET_SIZE=16, ROW_BITS=20 -> tkeep=2'b11, then 2'b10 on each row's last beat.
